// File: rtl/risc32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : risc32_bus_arbiter
// Description : Shares the external memory bus between instruction fetch and
//               the MEM-stage data port. MEM accesses win over fetches. Raises
//               per-stage stall requests until each access completes and can
//               abandon an in-flight fetch when the pipeline is flushed.
//               Optional bus watchdog is built when BUS_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module risc32_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o
`ifdef BUS_TIMEOUT_EN
    ,
    output logic        bus_err_o
`endif
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_IF_BUSY    = 2'd1;
    localparam logic [1:0] c_MEM_BUSY   = 2'd2;
    localparam logic [1:0] c_IF_DISCARD = 2'd3;

    localparam logic [31:0] c_ERR_DATA = 32'hFFFF_FFFF;

    // A watchdog limit of zero could never be reached by the counter.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  r_state, w_state;
    logic        r_bus_req, w_bus_req;
    logic        r_bus_we, w_bus_we;
    logic [3:0]  r_bus_sel, w_bus_sel;
    logic [31:0] r_bus_addr, w_bus_addr;
    logic [31:0] r_bus_wdata, w_bus_wdata;
    logic [31:0] r_if_rdata, w_if_rdata;
    logic [31:0] r_mem_rdata, w_mem_rdata;
    logic        r_if_ack, w_if_ack;
    logic        r_mem_ack, w_mem_ack;
    logic        w_tmo_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_TMO_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_bus_err;
    logic               w_bus_err;

    // The cycle that would bring the count up to the limit forces completion.
    assign w_tmo_hit = (r_state != c_IDLE) && ((r_tmo_cnt + 1'b1) == c_TMO_LIMIT);

    // Error pulse only when the watchdog actually ends the transaction; a flush
    // in IF_BUSY diverts to IF_DISCARD instead of completing.
    assign w_bus_err = w_tmo_hit && !bus_ack_i &&
                       !((r_state == c_IF_BUSY) && flush_i);

    // Watchdog counter: cleared on entering a busy state, counts stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_bus_err;
            if ((w_state != r_state) && (w_state != c_IDLE)) begin
                r_tmo_cnt <= '0;
            end else if ((r_state != c_IDLE) && !bus_ack_i) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign bus_err_o = r_bus_err;
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and next-register logic for the arbitration FSM.
    always_comb begin
        w_state     = r_state;
        w_bus_req   = r_bus_req;
        w_bus_we    = r_bus_we;
        w_bus_sel   = r_bus_sel;
        w_bus_addr  = r_bus_addr;
        w_bus_wdata = r_bus_wdata;
        w_if_rdata  = r_if_rdata;
        w_mem_rdata = r_mem_rdata;
        w_if_ack    = 1'b0;
        w_mem_ack   = 1'b0;

        case (r_state)
            c_IDLE: begin
                // Ack-pulse gating keeps a still-held request from re-issuing.
                if (mem_req_i && !r_mem_ack) begin
                    w_bus_req   = 1'b1;
                    w_bus_we    = mem_we_i;
                    w_bus_sel   = mem_sel_i;
                    w_bus_addr  = mem_addr_i;
                    w_bus_wdata = mem_wdata_i;
                    w_state     = c_MEM_BUSY;
                end else if (if_req_i && !r_if_ack && !flush_i) begin
                    w_bus_req  = 1'b1;
                    w_bus_we   = 1'b0;
                    w_bus_sel  = 4'hF;
                    w_bus_addr = if_addr_i;
                    w_state    = c_IF_BUSY;
                end
            end

            c_MEM_BUSY: begin
                if (bus_ack_i || w_tmo_hit) begin
                    w_bus_req = 1'b0;
                    w_bus_we  = 1'b0;
                    w_bus_sel = 4'h0;
                    if (!r_bus_we) begin
                        w_mem_rdata = bus_ack_i ? bus_rdata_i : c_ERR_DATA;
                    end
                    w_mem_ack = 1'b1;
                    w_state   = c_IDLE;
                end
            end

            c_IF_BUSY: begin
                if (bus_ack_i) begin
                    w_bus_req = 1'b0;
                    w_bus_we  = 1'b0;
                    w_bus_sel = 4'h0;
                    if (!flush_i) begin
                        w_if_rdata = bus_rdata_i;
                        w_if_ack   = 1'b1;
                    end
                    w_state = c_IDLE;
                end else if (flush_i) begin
                    // The bus cycle cannot be aborted; wait it out silently.
                    w_state = c_IF_DISCARD;
                end else if (w_tmo_hit) begin
                    w_bus_req  = 1'b0;
                    w_bus_we   = 1'b0;
                    w_bus_sel  = 4'h0;
                    w_if_rdata = c_ERR_DATA;
                    w_if_ack   = 1'b1;
                    w_state    = c_IDLE;
                end
            end

            c_IF_DISCARD: begin
                if (bus_ack_i || w_tmo_hit) begin
                    w_bus_req = 1'b0;
                    w_bus_we  = 1'b0;
                    w_bus_sel = 4'h0;
                    w_state   = c_IDLE;
                end
            end

            default: w_state = c_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_if_rdata  <= 32'h0;
            r_mem_rdata <= 32'h0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bus_req   <= w_bus_req;
            r_bus_we    <= w_bus_we;
            r_bus_sel   <= w_bus_sel;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_if_rdata  <= w_if_rdata;
            r_mem_rdata <= w_mem_rdata;
            r_if_ack    <= w_if_ack;
            r_mem_ack   <= w_mem_ack;
        end
    end

    assign bus_req_o      = r_bus_req;
    assign bus_we_o       = r_bus_we;
    assign bus_sel_o      = r_bus_sel;
    assign bus_addr_o     = r_bus_addr;
    assign bus_wdata_o    = r_bus_wdata;
    assign if_rdata_o     = r_if_rdata;
    assign mem_rdata_o    = r_mem_rdata;
    assign if_ack_o       = r_if_ack;
    assign mem_ack_o      = r_mem_ack;
    assign stallreq_if_o  = if_req_i && !r_if_ack;
    assign stallreq_mem_o = mem_req_i && !r_mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_risc32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc32_bus_arbiter
// Description : Scoreboard bench for risc32_bus_arbiter. Stimulus pushes the
//               expected bus transactions and ack data; a bus slave model and
//               an ack monitor pop and compare as the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc32_bus_arbiter;

`ifdef BUS_TIMEOUT_EN
    localparam int c_TMO = 4;
`else
    localparam int c_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
`ifdef BUS_TIMEOUT_EN
    logic        bus_err_o;
`endif

    risc32_bus_arbiter #(.TIMEOUT_CYCLES(c_TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_ack_o       (if_ack_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_ack_o      (mem_ack_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o)
`ifdef BUS_TIMEOUT_EN
        ,
        .bus_err_o      (bus_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];
    bus_t        exp_bus_q[$];
    logic [31:0] model_mem_rdata = 32'h0;

    int          slave_wait = 0;
    logic [31:0] slave_data = 32'h0;
    bit          slave_mute = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=no-response required=response-within-bound", name);
    endtask

    // Bus slave: acks after slave_wait cycles of bus_req_o and checks the
    // transaction against the expected bus order.
    initial begin
        int   scnt;
        bus_t e;
        scnt        = 0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            if (bus_req_o && !slave_mute && !rst) begin
                if (scnt >= slave_wait) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = slave_data;
                    scnt        = 0;
                    if (exp_bus_q.size() == 0) begin
                        check("bus_unexpected_txn", {31'h0, bus_req_o}, 32'h0);
                    end else begin
                        e = exp_bus_q.pop_front();
                        check("bus_we", {31'h0, bus_we_o}, {31'h0, e.we});
                        check("bus_sel", {28'h0, bus_sel_o}, {28'h0, e.sel});
                        check("bus_addr", bus_addr_o, e.addr);
                        if (e.we) check("bus_wdata", bus_wdata_o, e.wdata);
                    end
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Ack monitor: every ack pulse pops its expected data.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_ack_o) begin
                    check("if_stall_low_on_ack", {31'h0, stallreq_if_o}, 32'h0);
                    if (exp_if_q.size() == 0) check("if_ack_unexpected", {31'h0, if_ack_o}, 32'h0);
                    else check("if_rdata", if_rdata_o, exp_if_q.pop_front());
                end
                if (mem_ack_o) begin
                    check("mem_stall_low_on_ack", {31'h0, stallreq_mem_o}, 32'h0);
                    if (exp_mem_q.size() == 0) check("mem_ack_unexpected", {31'h0, mem_ack_o}, 32'h0);
                    else check("mem_rdata", mem_rdata_o, exp_mem_q.pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, {31'h0, bus_req_o}, 32'h0);
        check({tag, "_bus_we"}, {31'h0, bus_we_o}, 32'h0);
        check({tag, "_bus_sel"}, {28'h0, bus_sel_o}, 32'h0);
        check({tag, "_bus_addr"}, bus_addr_o, 32'h0);
        check({tag, "_bus_wdata"}, bus_wdata_o, 32'h0);
        check({tag, "_if_rdata"}, if_rdata_o, 32'h0);
        check({tag, "_mem_rdata"}, mem_rdata_o, 32'h0);
        check({tag, "_acks"}, {30'h0, if_ack_o, mem_ack_o}, 32'h0);
`ifdef BUS_TIMEOUT_EN
        check({tag, "_bus_err"}, {31'h0, bus_err_o}, 32'h0);
`endif
    endtask

    // Issue a fetch and wait for its ack; checks the stall request while waiting.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int wt);
        bit got;
        got        = 1'b0;
        slave_wait = wt;
        slave_data = data;
        exp_bus_q.push_back({1'b0, 4'hF, addr, 32'h0});
        exp_if_q.push_back(data);
        if_req_i  = 1'b1;
        if_addr_i = addr;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_ack_o) begin
                got = 1'b1;
                break;
            end
            check("if_stall_while_waiting", {31'h0, stallreq_if_o}, 32'h1);
        end
        if_req_i = 1'b0;
        if (!got) bound_expired("fetch_ack_timeout");
    endtask

    // Issue a MEM access and wait for its ack; returns cycles to ack.
    task automatic do_mem(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int wt, output int lat);
        bit got;
        got        = 1'b0;
        lat        = 0;
        slave_wait = wt;
        slave_data = rdata;
        exp_bus_q.push_back({we, sel, addr, wdata});
        if (!we) model_mem_rdata = rdata;
        exp_mem_q.push_back(model_mem_rdata);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_sel_i   = sel;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (mem_ack_o) begin
                got = 1'b1;
                break;
            end
            check("mem_stall_while_waiting", {31'h0, stallreq_mem_o}, 32'h1);
        end
        mem_req_i = 1'b0;
        if (!got) bound_expired("mem_ack_timeout");
    endtask

    initial begin
        int lat;
        bit got_m;
        bit got_i;
        rst         = 1'b1;
        flush_i     = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'h0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // Fetch only, slave acks two cycles after the strobe rises.
        do_fetch(32'h0000_0100, 32'h2402_0005, 2);
        repeat (3) @(negedge clk);
        check("if_rdata_hold", if_rdata_o, 32'h2402_0005);

        // Simultaneous MEM store and fetch: store must go first.
        slave_wait = 1;
        slave_data = 32'hCAFE_0002;
        exp_bus_q.push_back({1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF});
        exp_bus_q.push_back({1'b0, 4'hF, 32'h0000_0200, 32'h0});
        exp_mem_q.push_back(model_mem_rdata);
        exp_if_q.push_back(32'hCAFE_0002);
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_sel_i   = 4'hF;
        mem_addr_i  = 32'h0000_0040;
        mem_wdata_i = 32'hDEAD_BEEF;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0000_0200;
        got_m = 1'b0;
        got_i = 1'b0;
        @(negedge clk);
        check("priority_store_first_we", {31'h0, bus_we_o}, 32'h1);
        check("priority_if_stalled", {31'h0, stallreq_if_o}, 32'h1);
        for (int i = 0; i < 80 && !(got_m && got_i); i++) begin
            if (i != 0) @(negedge clk);
            if (mem_ack_o) begin
                check("if_stalled_during_mem_ack", {31'h0, stallreq_if_o}, 32'h1);
                mem_req_i = 1'b0;
                got_m     = 1'b1;
            end
            if (if_ack_o) begin
                check("mem_done_before_if", {31'h0, got_m}, 32'h1);
                if_req_i = 1'b0;
                got_i    = 1'b1;
            end
        end
        if (!(got_m && got_i)) bound_expired("priority_acks_timeout");
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
        repeat (2) @(negedge clk);

        // Flush while a fetch is on the bus: data dropped, strobe held until ack.
        slave_wait = 3;
        slave_data = 32'h0BAD_0BAD;
        exp_bus_q.push_back({1'b0, 4'hF, 32'h0000_0300, 32'h0});
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0300;
        got_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req_o) begin
                got_i = 1'b1;
                break;
            end
        end
        if (!got_i) bound_expired("flush_fetch_start_timeout");
        flush_i  = 1'b1;
        if_req_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        got_i   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus_ack_i) begin
                got_i = 1'b1;
                break;
            end
            check("discard_req_held", {31'h0, bus_req_o}, 32'h1);
            check("discard_addr_held", bus_addr_o, 32'h0000_0300);
            @(negedge clk);
        end
        if (!got_i) bound_expired("discard_ack_timeout");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("discard_no_if_ack", {31'h0, if_ack_o}, 32'h0);
            check("discard_bus_idle", {31'h0, bus_req_o}, 32'h0);
        end
        do_fetch(32'h0000_0304, 32'h1357_9BDF, 0);
        @(negedge clk);

        // Reset in the middle of a MEM access.
        slave_mute  = 1'b1;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'hF;
        mem_addr_i  = 32'h0000_0080;
        repeat (3) @(negedge clk);
        check("mem_busy_before_reset", {31'h0, bus_req_o}, 32'h1);
        rst       = 1'b1;
        mem_req_i = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        slave_mute = 1'b0;
        check_all_zero("midreset");
        model_mem_rdata = 32'h0;
        @(negedge clk);

        // Fresh zero-wait load, then a store that must not disturb mem_rdata_o.
        do_mem(1'b0, 4'hF, 32'h0000_0084, 32'h0, 32'h1234_5678, 0, lat);
        check("zero_wait_latency", lat, 32'd2);
        @(negedge clk);
        do_mem(1'b1, 4'h3, 32'h0000_0088, 32'h0000_55AA, 32'hFFFF_0000, 1, lat);
        @(negedge clk);
        check("store_keeps_mem_rdata", mem_rdata_o, 32'h1234_5678);

`ifdef BUS_TIMEOUT_EN
        // Silent slave: watchdog completes the load with the error pattern.
        slave_mute = 1'b1;
        exp_mem_q.push_back(32'hFFFF_FFFF);
        model_mem_rdata = 32'hFFFF_FFFF;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h0000_0090;
        got_m = 1'b0;
        lat   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (mem_ack_o) begin
                got_m = 1'b1;
                break;
            end
        end
        mem_req_i = 1'b0;
        if (!got_m) bound_expired("timeout_ack_timeout");
        check("timeout_bus_err_pulse", {31'h0, bus_err_o}, 32'h1);
        check("timeout_latency", lat, 32'd5);
        check("timeout_bus_req_low", {31'h0, bus_req_o}, 32'h0);
        @(negedge clk);
        check("timeout_bus_err_single", {31'h0, bus_err_o}, 32'h0);
        slave_mute = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("if_queue_drained", exp_if_q.size(), 32'd0);
        check("mem_queue_drained", exp_mem_q.size(), 32'd0);
        check("bus_queue_drained", exp_bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
